// File: rtl/venda_pkg.sv
// Shared types and constants for the venda_ctrl coin/change controller.
package venda_pkg;

    localparam int unsigned SALDO_W = 6;
    localparam int unsigned COIN_W  = 5;

    localparam logic [COIN_W-1:0] COIN5  = 5'd5;
    localparam logic [COIN_W-1:0] COIN10 = 5'd10;
    localparam logic [COIN_W-1:0] COIN20 = 5'd20;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        VEND,
        CHANGE
    } state_t;

    function automatic logic is_valid_coin(input logic [COIN_W-1:0] c);
        return (c == COIN5) || (c == COIN10) || (c == COIN20);
    endfunction

endpackage

// File: rtl/venda_ctrl_if.sv
// Coin-slot four-phase handshakes and the change valid/ready channel.
interface venda_ctrl_if;

    logic                         req0;
    logic                         req1;
    logic [venda_pkg::COIN_W-1:0] coin0;
    logic [venda_pkg::COIN_W-1:0] coin1;
    logic                         ack0;
    logic                         ack1;
    logic                         rej;
    logic                         change_valid;
    logic [venda_pkg::COIN_W-1:0] change_coin;
    logic                         change_ready;

    // master: coin sources and dispenser; slave: the controller
    modport master (
        output req0, req1, coin0, coin1, change_ready,
        input  ack0, ack1, rej, change_valid, change_coin
    );

    modport slave (
        input  req0, req1, coin0, coin1, change_ready,
        output ack0, ack1, rej, change_valid, change_coin
    );

endinterface

// File: rtl/venda_ctrl_rr_arb2.sv
// Two-requester round-robin arbiter; one-hot grant, slot 0 wins the first tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_grant;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= 1'b1;
        end else if (gnt != '0) begin
            last_grant <= gnt[1];
        end
    end

endmodule

// File: rtl/venda_ctrl.sv
// Vending controller: arbitrated coin intake, sale detection, 20/10/5 change payout.
// Optional `VENDA_REFUND_EN: refund request in IDLE pays out the whole balance.
module venda_ctrl
    import venda_pkg::*;
#(
    parameter int unsigned PRICE = 40
) (
    input  logic               clk,
    input  logic               reset,
    venda_ctrl_if.slave        bus,
    input  logic               refund,
    output logic               vend,
    output logic [SALDO_W-1:0] saldo,
    output logic               busy
);

    localparam logic [SALDO_W-1:0] PRICE_S = SALDO_W'(PRICE);

    state_t              state, state_next;
    logic [SALDO_W-1:0]  saldo_next;
    logic [1:0]          armed;
    logic [1:0]          req_v;
    logic [1:0]          elig;
    logic [1:0]          gnt;
    logic [1:0]          ack_next;
    logic                rej_next;
    logic [COIN_W-1:0]   coin_sel;
    logic [COIN_W-1:0]   chg_coin;

`ifndef VENDA_REFUND_EN
    logic unused_refund;
    assign unused_refund = refund;
`endif

    assign req_v    = {bus.req1, bus.req0};
    assign elig     = req_v & armed & {2{state == IDLE}};
    assign coin_sel = gnt[1] ? bus.coin1 : bus.coin0;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (elig),
        .gnt   (gnt)
    );

    always_comb begin
        chg_coin = COIN5;
        if (saldo >= SALDO_W'(COIN20)) begin
            chg_coin = COIN20;
        end else if (saldo >= SALDO_W'(COIN10)) begin
            chg_coin = COIN10;
        end
    end

    always_comb begin
        state_next = state;
        saldo_next = saldo;
        ack_next   = '0;
        rej_next   = 1'b0;
        unique case (state)
            IDLE: begin
                if (gnt != '0) begin
                    if (is_valid_coin(coin_sel)) begin
                        saldo_next = saldo + {1'b0, coin_sel};
                    end else begin
                        rej_next = 1'b1;
                    end
                    ack_next   = gnt;
                    state_next = CHECK;
                end
`ifdef VENDA_REFUND_EN
                // a same-cycle coin grant takes precedence over refund
                else if (refund && (saldo != '0)) begin
                    state_next = CHANGE;
                end
`endif
            end
            CHECK: begin
                state_next = (saldo >= PRICE_S) ? VEND : IDLE;
            end
            VEND: begin
                saldo_next = saldo - PRICE_S;
                state_next = (saldo_next != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                if (bus.change_ready) begin
                    saldo_next = saldo - {1'b0, chg_coin};
                    if (saldo_next == '0) begin
                        state_next = IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            saldo    <= '0;
            armed    <= '1;
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b0;
            bus.rej  <= 1'b0;
        end else begin
            state    <= state_next;
            saldo    <= saldo_next;
            // grant implies req high, so disarm and re-arm never collide
            armed    <= (armed & ~gnt) | ~req_v;
            bus.ack0 <= ack_next[0];
            bus.ack1 <= ack_next[1];
            bus.rej  <= rej_next;
        end
    end

    assign vend             = (state == VEND);
    assign busy             = (state != IDLE);
    assign bus.change_valid = (state == CHANGE);
    assign bus.change_coin  = (state == CHANGE) ? chg_coin : '0;

endmodule

// File: tb/tb_venda_ctrl.sv
// Scoreboard bench for venda_ctrl: stimulus queues expected events, a negedge monitor checks them.
module tb_venda_ctrl;
    import venda_pkg::*;

    localparam int unsigned PRICE = 40;

    typedef enum logic [1:0] {EV_ACK0, EV_ACK1, EV_VEND, EV_CHG} ev_kind_t;
    typedef struct packed {
        ev_kind_t    kind;
        logic        rej;
        logic [4:0]  coin;
        logic [5:0]  saldo;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       refund;
    logic       vend;
    logic       busy;
    logic [5:0] saldo;

    venda_ctrl_if bus ();

    venda_ctrl #(.PRICE(PRICE)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .refund (refund),
        .vend   (vend),
        .saldo  (saldo),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    ev_t         exp_q[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned n_ack = 0;
    int          m_saldo = 0;

    logic        stall_prev = 1'b0;
    logic [4:0]  stall_coin = '0;

    // monitor: every DUT-presented event pops one expectation
    always @(negedge clk) begin
        ev_t obs;
        bit  have;
        ev_t e;
        have = 1'b0;
        obs  = '0;
        if (reset === 1'b1) begin
            if (stall_prev) begin
                n_cmp++;
                if (!(bus.change_valid === 1'b1 && bus.change_coin === stall_coin)) begin
                    n_err++;
                    $display("FAIL stall_hold: valid=%0b coin=%0d, required valid=1 coin=%0d",
                             bus.change_valid, bus.change_coin, stall_coin);
                end
            end
            stall_prev = bus.change_valid && !bus.change_ready;
            stall_coin = bus.change_coin;

            obs.rej   = bus.rej;
            obs.saldo = saldo;
            if (bus.ack0) begin
                obs.kind = EV_ACK0; have = 1'b1; n_ack++;
            end else if (bus.ack1) begin
                obs.kind = EV_ACK1; have = 1'b1; n_ack++;
            end else if (vend) begin
                obs.kind = EV_VEND; have = 1'b1;
            end else if (bus.change_valid && bus.change_ready) begin
                obs.kind = EV_CHG; obs.coin = bus.change_coin; have = 1'b1;
            end

            if (have) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_event: kind=%0d rej=%0b coin=%0d saldo=%0d, required no event",
                             obs.kind, obs.rej, obs.coin, obs.saldo);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        n_err++;
                        $display("FAIL event: got kind=%0d rej=%0b coin=%0d saldo=%0d, required kind=%0d rej=%0b coin=%0d saldo=%0d",
                                 obs.kind, obs.rej, obs.coin, obs.saldo, e.kind, e.rej, e.coin, e.saldo);
                    end
                end
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic check_zero(input string name);
        check(name, int'({bus.ack0, bus.ack1, bus.rej, vend, bus.change_valid,
                          bus.change_coin, saldo, busy}), 0);
    endtask

    task automatic push_ev(input ev_kind_t k, input int coin, input int s);
        ev_t e;
        e.kind  = k;
        e.rej   = 1'b0;
        e.coin  = 5'(coin);
        e.saldo = 6'(s);
        exp_q.push_back(e);
    endtask

    // hand model of the sale and payout that one accepted coin triggers
    task automatic push_coin(input int slot, input int value);
        ev_t e;
        int  c;
        e.kind = (slot == 0) ? EV_ACK0 : EV_ACK1;
        e.coin = '0;
        e.rej  = 1'b1;
        if (value == 5 || value == 10 || value == 20) begin
            m_saldo += value;
            e.rej = 1'b0;
        end
        e.saldo = 6'(m_saldo);
        exp_q.push_back(e);
        if (m_saldo >= PRICE) begin
            push_ev(EV_VEND, 0, m_saldo);
            m_saldo -= PRICE;
            while (m_saldo > 0) begin
                c = (m_saldo >= 20) ? 20 : (m_saldo >= 10) ? 10 : 5;
                push_ev(EV_CHG, c, m_saldo);
                m_saldo -= c;
            end
        end
    endtask

    task automatic insert(input int slot, input int value, input int hold);
        bit got;
        got = 1'b0;
        push_coin(slot, value);
        if (slot == 0) begin
            bus.coin0 = 5'(value); bus.req0 = 1'b1;
        end else begin
            bus.coin1 = 5'(value); bus.req1 = 1'b1;
        end
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            got = (slot == 0) ? bus.ack0 : bus.ack1;
        end
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL ack_timeout: slot %0d ack=0, required 1", slot);
        end
        repeat (hold) step();
        if (slot == 0) bus.req0 = 1'b0;
        else           bus.req1 = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            step();
            done = !busy;
        end
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL idle_timeout: busy=%0b, required 0", busy);
        end
    endtask

    task automatic wait_ack(input int slot, output int cycles);
        bit got;
        got = 1'b0;
        cycles = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            cycles++;
            got = (slot == 0) ? bus.ack0 : bus.ack1;
        end
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL ack_timeout: slot %0d ack=0, required 1", slot);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int a0;
        bit seen;

        reset = 1'b0;
        refund = 1'b0;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.coin0 = '0;  bus.coin1 = '0;
        bus.change_ready = 1'b1;
        #1;
        check_zero("reset_outputs");
        step();
        step();
        reset = 1'b1;
        step();

        // round-robin: simultaneous requests, slot 0 wins first, slot 1 two cycles later
        bus.coin0 = 5'd5; bus.coin1 = 5'd5;
        push_coin(0, 5); push_coin(1, 5);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        wait_ack(0, k);
        wait_ack(1, k);
        check("rr_ack1_delay", k, 2);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        step(); step();
        push_coin(0, 5); push_coin(1, 5);
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        wait_ack(1, k);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        wait_idle();
        insert(1, 20, 0);
        wait_idle();

        // exact price
        insert(0, 20, 0); wait_idle();
        insert(0, 20, 0); wait_idle();
        check("exact_saldo", int'(saldo), 0);

        // small change
        insert(0, 20, 0); wait_idle();
        insert(0, 5, 0);  wait_idle();
        insert(0, 20, 0); wait_idle();

        // multi-coin change with a 3-cycle dispenser stall
        insert(0, 10, 0); wait_idle();
        insert(0, 5, 0);  wait_idle();
        insert(0, 20, 0); wait_idle();
        bus.change_ready = 1'b0;
        insert(0, 20, 0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = bus.change_valid;
        end
        check("stall_valid_seen", int'(seen), 1);
        step(); step(); step();
        bus.change_ready = 1'b1;
        wait_idle();

        // reject, then a held request must not be re-granted
        insert(0, 7, 0); wait_idle();
        check("reject_saldo", int'(saldo), 0);
        a0 = int'(n_ack);
        insert(1, 5, 6);
        step();
        check("held_req_single_ack", int'(n_ack) - a0, 1);
        wait_idle();
        insert(1, 20, 0); wait_idle();
        insert(0, 20, 0); wait_idle();

        // refund
        insert(0, 20, 0); wait_idle();
        insert(1, 10, 0); wait_idle();
        refund = 1'b1;
`ifdef VENDA_REFUND_EN
        push_ev(EV_CHG, 20, 30);
        push_ev(EV_CHG, 10, 10);
        m_saldo = 0;
        step();
        refund = 1'b0;
        check("refund_busy", int'(busy), 1);
        wait_idle();
        check("refund_saldo", int'(saldo), 0);
`else
        step(); step(); step();
        refund = 1'b0;
        check("refund_ignored_saldo", int'(saldo), 30);
        check("refund_ignored_busy", int'(busy), 0);
        insert(0, 10, 0); wait_idle();
`endif

        // asynchronous reset while change is pending
        insert(0, 10, 0); wait_idle();
        insert(0, 10, 0); wait_idle();
        insert(0, 10, 0); wait_idle();
        bus.change_ready = 1'b0;
        insert(0, 20, 0);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step();
            seen = bus.change_valid;
        end
        check("pre_reset_change_valid", int'(seen), 1);
        #2;
        reset = 1'b0;
        #1;
        check_zero("reset_mid_change");
        exp_q.delete();
        m_saldo = 0;
        bus.change_ready = 1'b1;
        step();
        reset = 1'b1;
        step();

        insert(1, 20, 0); wait_idle();
        insert(0, 20, 0); wait_idle();
        step();

        check("queue_drained", exp_q.size(), 0);
        check("final_saldo", int'(saldo), 0);
        check("final_busy", int'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/venda_ctrl.md
# venda_ctrl

Coin-acceptance and change-dispensing controller for the vending datapath. Arbitrates two coin slots round-robin onto a single balance accumulator, compares the balance against a fixed price, pulses `vend` on a sale, then pays out the excess as 5/10/20 coins over a valid/ready handshake. It sits between the coin-source blocks (memory-fed coin readers) and the dispenser.

## Interface

Parameters:
- `PRICE`, default 40: item price. Must be a multiple of 5 in [5,45] so that `PRICE+15` fits in 6 bits.

Ports:
- `clk` input 1: clock, all state on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req0` / `req1` input 1: coin request, slot 0 / slot 1, four-phase.
- `coin0` / `coin1` input 5: coin value, stable while the matching req is high.
- `ack0` / `ack1` output 1: registered one-cycle accept pulse per slot.
- `rej` output 1: high together with an ack when the coin is not 5, 10 or 20.
- `vend` output 1: one-cycle sale pulse.
- `change_valid` output 1: change coin offered.
- `change_coin` output 5: change coin value, 20, 10 or 5.
- `change_ready` input 1: dispenser accepts change coin.
- `saldo` output 6: balance register. Shows the remaining change while in CHANGE.
- `busy` output 1: high in any state other than IDLE.
- `refund` input 1: refund request. Used only with `VENDA_REFUND_EN`.

## Operation

States: IDLE, CHECK, VEND, CHANGE.
- **IDLE**
  - A slot is eligible when its `req` is high and it is armed.
  - If both are eligible, grant the slot not granted last. `last_grant` resets to 1, so slot 0 wins first.
  - On a grant:
    - Valid coin: `saldo <= saldo + coin`.
    - Invalid coin: `saldo` unchanged and `rej = 1`.
    - In both cases assert `ack` for the granted slot, disarm that slot, and go to CHECK.
  - If nothing is eligible, stay in IDLE.
- **Arming:** a slot re-arms on any cycle its `req` is sampled low. Re-arming happens in every state.
- **CHECK**
  - If `saldo >= PRICE`, go to VEND.
  - Otherwise go to IDLE.
- **VEND**
  - `vend = 1` for this one cycle, and `saldo <= saldo - PRICE`.
  - Next state is CHANGE if the new `saldo` is nonzero, otherwise IDLE.
- **CHANGE**
  - `change_valid = 1`.
  - `change_coin` = 20 if `saldo >= 20`, else 10 if `saldo >= 10`, else 5.
  - On `change_valid && change_ready`: `saldo <= saldo - change_coin`. If the result is 0, go to IDLE.
  - `change_coin` is held stable while `ready` is low.
- No coin is granted in CHECK, VEND or CHANGE. Requests simply wait.
- Arithmetic is unsigned 6-bit. Given the PRICE constraint, no overflow or underflow is possible.

## Timing

- **Reset values:** state IDLE, `saldo` 0, all outputs 0, both slots armed, `last_grant` 1.
- **Coin path:** req is sampled at edge N. Ack is high in cycle N..N+1. CHECK lasts one cycle. The earliest `vend` is the cycle after CHECK.
- **Coin-to-vend latency:** 2 cycles from the grant edge.
- **Change path:** first `change_valid` is the cycle after VEND. Each coin handshake takes ≥1 cycle.
- **Requests during busy:** a req raised during CHANGE is granted in the first IDLE cycle.
- **Simultaneous events:**
  - A req falling in the same cycle as its ack is legal.
  - Both slots eligible in the same cycle resolve by round-robin.
- **Reset mid-operation:** immediate asynchronous clear. Pending change is discarded and `vend`/`ack` drop at once.

## Configuration

- **`VENDA_REFUND_EN` defined:**
  - In IDLE, `refund` high with `saldo != 0` goes directly to CHANGE and pays out the whole `saldo`. No `vend` is issued.
  - If a coin grant and `refund` occur in the same cycle, the coin grant wins and the refund is ignored.
- **`VENDA_REFUND_EN` undefined:** `refund` is ignored. Balance is released only via a sale.

## Structure

- Package `venda_pkg` holds:
  - coin constants `COIN5`, `COIN10`, `COIN20`;
  - the state enum;
  - the `is_valid_coin` function;
  - saldo and coin width constants (6, 5).
- Sub-module `rr_arb2`: two-requester round-robin arbiter with `last_grant` register and one-hot grant output.

## Test plan

- **Exact price:** slot 0 coins 20, 20 → second ack, `vend` 1 cycle, `saldo` 0, no `change_valid`, back to IDLE.
- **Small change:** slot 0 coins 20, 5, 20 → `vend`, one change coin 5, `saldo` 0.
- **Multi-coin change with stall:** coins 10, 5, 20, 20 (55) → `vend`, change 10 then 5. Hold `change_ready` low for 3 cycles; `change_valid`/`change_coin` must stay stable.
- **Round-robin:** `req0` and `req1` raised together after reset → `ack0` first, then `ack1` two cycles later. A repeat simultaneous request → `ack0` first again.
- **Reject and arming:**
  - Coin 7 → `ack` with `rej` = 1, `saldo` unchanged.
  - `req` held high after its ack → no second ack until `req` drops.
- **Reset and refund:**
  - Reset asserted during CHANGE → all outputs 0 immediately.
  - With `VENDA_REFUND_EN`: coins 20, 10 then `refund` → change 20, 10, no `vend`.
